// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared FSM encodings and constants for the BCD-to-binary converter
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // A failed conversion reports an all-ones result; users slice this to their width.
  localparam logic [31:0] ERR_FILL = '1;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// rtl/bcd_to_bin_seq_if.sv - request/result bundle between a requester and the converter
interface bcd_to_bin_seq_if #(
  parameter int NDIG = 4
);

  localparam int BW = $clog2(10**NDIG);

  logic              start;
  logic [4*NDIG-1:0] a;
  logic [BW-1:0]     y;
  logic              busy;
  logic              done;
  logic              err;

  modport master (output start, output a, input y, input busy, input done, input err);
  modport slave  (input start, input a, output y, output busy, output done, output err);

endinterface

// File: rtl/bcd_mul10_add.sv
// rtl/bcd_mul10_add.sv - one MSD-first conversion step: acc*10 + digit, flagging non-BCD digits
module bcd_mul10_add
  import bcd_pkg::*;
#(
  parameter int BW = 14
) (
  input  logic [BW-1:0] acc,
  input  logic [3:0]    digit,
  output logic [BW-1:0] next_acc,
  output logic          digit_bad
);

  // Shift-and-add keeps the step multiplier-free; wraps silently only for bad digits.
  assign next_acc  = (acc << 3) + (acc << 1) + BW'(digit);
  assign digit_bad = (digit > BCD_MAX);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential packed-BCD to binary converter, one digit per cycle
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_to_bin_seq_if.slave  bus
);

  localparam int             BW       = $clog2(10**NDIG);
  localparam int             CW       = $clog2(NDIG + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(NDIG - 1);
  localparam logic [BW-1:0]  Y_ERR    = ERR_FILL[BW-1:0];

  state_t            state_q, state_d;
  logic [4*NDIG-1:0] sr_q, sr_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic [BW-1:0]     y_q, y_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              errf_q, errf_d;
  logic              err_q, err_d;
  logic [BW-1:0]     next_acc;
  logic              digit_bad;
  logic              last_digit;
  logic              err_now;

  bcd_mul10_add #(.BW(BW)) u_step (
    .acc       (acc_q),
    .digit     (sr_q[4*NDIG-1 -: 4]),
    .next_acc  (next_acc),
    .digit_bad (digit_bad)
  );

  assign last_digit = (cnt_q == CNT_LAST);
  assign err_now    = errf_q | digit_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CONV;
      CONV:    if (last_digit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
  end

  always_comb begin
    sr_d   = sr_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    errf_d = errf_q;
    y_d    = y_q;
    err_d  = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d   = bus.a;
          acc_d  = '0;
          cnt_d  = '0;
          errf_d = 1'b0;
        end
      end
      CONV: begin
        acc_d  = next_acc;
        sr_d   = sr_q << 4;
        cnt_d  = cnt_q + CW'(1);
        errf_d = err_now;
        // The final digit's step feeds the result registers directly.
        if (last_digit) begin
          y_d   = err_now ? Y_ERR : next_acc;
          err_d = err_now;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      errf_q <= 1'b0;
      y_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      errf_q <= errf_d;
      y_q    <= y_d;
      err_q  <= err_d;
    end
  end

  assign bus.y   = y_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - directed self-checking bench for bcd_to_bin_seq (NDIG=4 and NDIG=1)
module tb_bcd_to_bin_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bcd_to_bin_seq_if #(.NDIG(4)) bif ();
  bcd_to_bin_seq_if #(.NDIG(1)) bif1 ();

  bcd_to_bin_seq #(.NDIG(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bif));
  bcd_to_bin_seq #(.NDIG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bif1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts a conversion, scrambles a after capture, and measures done latency and busy length.
  task automatic run_conv(input logic [15:0] val, output int lat, output int nb);
    bif.a     = val;
    bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    bif.a     = 16'hFFFF;
    lat = -1;
    nb  = 0;
    for (int i = 0; i < 12; i++) begin
      if (bif.busy) nb++;
      if (bif.done && lat < 0) lat = i;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_conv1(input logic [3:0] val, output int lat, output int nb);
    bif1.a     = val;
    bif1.start = 1'b1;
    @(posedge clk); #1;
    bif1.start = 1'b0;
    bif1.a     = 4'h0;
    lat = -1;
    nb  = 0;
    for (int i = 0; i < 8; i++) begin
      if (bif1.busy) nb++;
      if (bif1.done && lat < 0) lat = i;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (bif.y !== 14'h0)   begin errors++; $display("FAIL reset_y got %h want 0000", bif.y); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bif.busy); end
    checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bif.done); end
    checks++; if (bif.err !== 1'b0)  begin errors++; $display("FAIL reset_err got %b want 0", bif.err); end
    checks++; if (bif1.y !== 4'h0)   begin errors++; $display("FAIL reset_y1 got %h want 0", bif1.y); end
  endtask

  task automatic test_basic;
    int lat, nb;
    run_conv(16'h1234, lat, nb);
    checks++; if (lat !== 4)          begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
    checks++; if (nb !== 5)           begin errors++; $display("FAIL basic_busy_cycles got %0d want 5", nb); end
    checks++; if (bif.y !== 14'h04D2) begin errors++; $display("FAIL basic_y got %h want 04d2", bif.y); end
    checks++; if (bif.err !== 1'b0)   begin errors++; $display("FAIL basic_err got %b want 0", bif.err); end
  endtask

  task automatic test_extremes;
    int lat, nb;
    run_conv(16'h9999, lat, nb);
    checks++; if (bif.y !== 14'h270F) begin errors++; $display("FAIL max_y got %h want 270f", bif.y); end
    checks++; if (bif.err !== 1'b0)   begin errors++; $display("FAIL max_err got %b want 0", bif.err); end
    run_conv(16'h0000, lat, nb);
    checks++; if (bif.y !== 14'h0000) begin errors++; $display("FAIL zero_y got %h want 0000", bif.y); end
    checks++; if (bif.err !== 1'b0)   begin errors++; $display("FAIL zero_err got %b want 0", bif.err); end
  endtask

  task automatic test_error;
    int lat, nb;
    run_conv(16'h12A4, lat, nb);
    checks++; if (bif.y !== 14'h3FFF) begin errors++; $display("FAIL bad_mid_y got %h want 3fff", bif.y); end
    checks++; if (bif.err !== 1'b1)   begin errors++; $display("FAIL bad_mid_err got %b want 1", bif.err); end
    checks++; if (lat !== 4)          begin errors++; $display("FAIL bad_mid_latency got %0d want 4", lat); end
    run_conv(16'h0042, lat, nb);
    checks++; if (bif.y !== 14'd42)   begin errors++; $display("FAIL after_bad_y got %0d want 42", bif.y); end
    checks++; if (bif.err !== 1'b0)   begin errors++; $display("FAIL after_bad_err got %b want 0", bif.err); end
    run_conv(16'hB000, lat, nb);
    checks++; if (bif.y !== 14'h3FFF) begin errors++; $display("FAIL bad_msd_y got %h want 3fff", bif.y); end
    checks++; if (bif.err !== 1'b1)   begin errors++; $display("FAIL bad_msd_err got %b want 1", bif.err); end
  endtask

  task automatic test_back_to_back;
    int prev, nd;
    bif.a     = 16'h0005;
    bif.start = 1'b1;
    prev = -1;
    nd   = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (bif.done) begin
        nd++;
        checks++;
        if (bif.y !== 14'd5) begin errors++; $display("FAIL b2b_y got %0d want 5 at cycle %0d", bif.y, i); end
        checks++;
        if (prev >= 0) begin
          if (i - prev !== 6) begin errors++; $display("FAIL b2b_spacing got %0d want 6", i - prev); end
        end else begin
          if (i !== 5) begin errors++; $display("FAIL b2b_first_done got cycle %0d want 5", i); end
        end
        prev = i;
      end
    end
    bif.start = 1'b0;
    checks++; if (nd !== 5) begin errors++; $display("FAIL b2b_count got %0d want 5", nd); end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_mid;
    int lat, nb, nd;
    bif.a     = 16'h1234;
    bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (bif.y !== 14'h0)   begin errors++; $display("FAIL midrst_y got %h want 0000", bif.y); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bif.busy); end
    checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bif.done); end
    checks++; if (bif.err !== 1'b0)  begin errors++; $display("FAIL midrst_err got %b want 0", bif.err); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bif.done || bif.busy) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL midrst_abandon got %0d active cycles want 0", nd); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_conv(16'h0777, lat, nb);
    checks++; if (lat !== 4)         begin errors++; $display("FAIL postrst_latency got %0d want 4", lat); end
    checks++; if (bif.y !== 14'd777) begin errors++; $display("FAIL postrst_y got %0d want 777", bif.y); end
    checks++; if (bif.err !== 1'b0)  begin errors++; $display("FAIL postrst_err got %b want 0", bif.err); end
  endtask

  task automatic test_ndig1;
    int lat, nb;
    run_conv1(4'h7, lat, nb);
    checks++; if (lat !== 1)        begin errors++; $display("FAIL n1_latency got %0d want 1", lat); end
    checks++; if (nb !== 2)         begin errors++; $display("FAIL n1_busy_cycles got %0d want 2", nb); end
    checks++; if (bif1.y !== 4'd7)  begin errors++; $display("FAIL n1_y got %0d want 7", bif1.y); end
    checks++; if (bif1.err !== 1'b0) begin errors++; $display("FAIL n1_err got %b want 0", bif1.err); end
    run_conv1(4'hF, lat, nb);
    checks++; if (bif1.y !== 4'hF)  begin errors++; $display("FAIL n1_bad_y got %h want f", bif1.y); end
    checks++; if (bif1.err !== 1'b1) begin errors++; $display("FAIL n1_bad_err got %b want 1", bif1.err); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bif.start  = 1'b0;
    bif.a      = '0;
    bif1.start = 1'b0;
    bif1.a     = '0;
    test_reset;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_basic;
    test_extremes;
    test_error;
    test_back_to_back;
    test_reset_mid;
    test_ndig1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
